// File: rtl/contador_mod_updown.sv
// Modulo-programmable up/down counter with enable, synchronous clear/load,
// wrap-or-saturate end behaviour, combinational terminal count and a registered wrap pulse.
module contador_mod_updown #(
   parameter int N      = 8,
   parameter int MODULO = 256,
   parameter int SAT    = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         up_dn,
   input  logic         clr,
   input  logic         load,
   input  logic [N-1:0] load_val,
   output logic [N-1:0] valor,
   output logic         tc,
   output logic         wrap
);

   // Top of range held one bit wider so MODULO == 2**N still compares cleanly.
   localparam logic [N:0]   MAX_X = (N+1)'(MODULO - 1);
   localparam logic [N-1:0] MAX_N = MAX_X[N-1:0];
   localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] valor_q, valor_d;
   logic         wrap_q, wrap_d;
   logic         at_top, at_bot;
   logic         load_over;

   always_comb begin
      at_top    = ({1'b0, valor_q} == MAX_X);
      at_bot    = (valor_q == '0);
      load_over = ({1'b0, load_val} > MAX_X);
      tc        = en & ~clr & ~load & ((up_dn & at_top) | (~up_dn & at_bot));

      valor_d = valor_q;
      wrap_d  = tc;
      if (clr) begin
         valor_d = '0;
      end else if (load) begin
         valor_d = load_over ? MAX_N : load_val;
      end else if (en) begin
         if (up_dn) begin
            if (at_top) valor_d = (SAT != 0) ? MAX_N : '0;
            else        valor_d = valor_q + ONE_N;
         end else begin
            if (at_bot) valor_d = (SAT != 0) ? '0 : MAX_N;
            else        valor_d = valor_q - ONE_N;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valor_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         valor_q <= valor_d;
         wrap_q  <= wrap_d;
      end
   end

   assign valor = valor_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_contador_mod_updown.sv
// Directed bench for contador_mod_updown: modulo-10 wrap, modulo-10 saturate
// and full-range modulo-16 instances sharing one clock and reset.
module tb_contador_mod_updown;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic       a_en = 0, a_up = 0, a_clr = 0, a_load = 0;
   logic [3:0] a_lv = '0, a_valor;
   logic       a_tc, a_wrap;

   logic       s_en = 0, s_up = 0, s_clr = 0, s_load = 0;
   logic [3:0] s_lv = '0, s_valor;
   logic       s_tc, s_wrap;

   logic       f_en = 0, f_up = 0, f_clr = 0, f_load = 0;
   logic [3:0] f_lv = '0, f_valor;
   logic       f_tc, f_wrap;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   contador_mod_updown #(.N(4), .MODULO(10), .SAT(0)) u_a (
      .clk(clk), .rst(rst), .en(a_en), .up_dn(a_up), .clr(a_clr), .load(a_load),
      .load_val(a_lv), .valor(a_valor), .tc(a_tc), .wrap(a_wrap));

   contador_mod_updown #(.N(4), .MODULO(10), .SAT(1)) u_s (
      .clk(clk), .rst(rst), .en(s_en), .up_dn(s_up), .clr(s_clr), .load(s_load),
      .load_val(s_lv), .valor(s_valor), .tc(s_tc), .wrap(s_wrap));

   contador_mod_updown #(.N(4), .MODULO(16), .SAT(0)) u_f (
      .clk(clk), .rst(rst), .en(f_en), .up_dn(f_up), .clr(f_clr), .load(f_load),
      .load_val(f_lv), .valor(f_valor), .tc(f_tc), .wrap(f_wrap));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_tests++;
      if (a_valor !== 4'd0 || a_wrap !== 1'b0 || s_valor !== 4'd0 || f_valor !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_init: valor a/s/f=%0d/%0d/%0d wrap=%b, want 0/0/0 wrap=0",
                  a_valor, s_valor, f_valor, a_wrap);
      end
      tick();
      rst = 1'b1;
      a_en = 1'b1; a_up = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      n_tests++;
      if (a_valor !== 4'd7) begin
         n_fail++;
         $display("FAIL reset_precount: valor=%0d want 7", a_valor);
      end
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (a_valor !== 4'd0 || a_wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: valor=%0d wrap=%b want 0/0", a_valor, a_wrap);
      end
      tick();
      tick();
      n_tests++;
      if (a_valor !== 4'd0 || a_wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_held: valor=%0d wrap=%b want 0/0", a_valor, a_wrap);
      end
      rst = 1'b1;
      a_en = 1'b0;
      tick();
      n_tests++;
      if (a_valor !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_release_hold: valor=%0d want 0", a_valor);
      end
   endtask

   task automatic test_up_wrap();
      a_clr = 1'b1; tick(); a_clr = 1'b0;
      a_en = 1'b1; a_up = 1'b1;
      #1;
      for (int i = 0; i < 10; i++) begin
         n_tests++;
         if (a_valor !== 4'(i) || a_tc !== (i == 9) || a_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL up_step%0d: valor=%0d tc=%b wrap=%b want %0d/%b/0",
                     i, a_valor, a_tc, a_wrap, i, (i == 9));
         end
         tick();
      end
      n_tests++;
      if (a_valor !== 4'd0 || a_wrap !== 1'b1 || a_tc !== 1'b0) begin
         n_fail++;
         $display("FAIL up_wrap: valor=%0d wrap=%b tc=%b want 0/1/0", a_valor, a_wrap, a_tc);
      end
      tick();
      n_tests++;
      if (a_valor !== 4'd1 || a_wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL up_after_wrap: valor=%0d wrap=%b want 1/0", a_valor, a_wrap);
      end
      a_en = 1'b0;
   endtask

   task automatic test_down_wrap();
      logic [3:0] ev [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
      logic       et [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic       ew [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      a_lv = 4'd1; a_load = 1'b1; tick(); a_load = 1'b0;
      a_en = 1'b1; a_up = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (a_valor !== ev[i] || a_tc !== et[i] || a_wrap !== ew[i]) begin
            n_fail++;
            $display("FAIL down_step%0d: valor=%0d tc=%b wrap=%b want %0d/%b/%b",
                     i, a_valor, a_tc, a_wrap, ev[i], et[i], ew[i]);
         end
         tick();
      end
      a_en = 1'b0;
   endtask

   task automatic test_saturate();
      logic [3:0] uv [5] = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
      logic       ut [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic       uw [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [3:0] dv [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
      logic       dw [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      s_lv = 4'd8; s_load = 1'b1; tick(); s_load = 1'b0;
      s_en = 1'b1; s_up = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (s_valor !== uv[i] || s_tc !== ut[i] || s_wrap !== uw[i]) begin
            n_fail++;
            $display("FAIL sat_up%0d: valor=%0d tc=%b wrap=%b want %0d/%b/%b",
                     i, s_valor, s_tc, s_wrap, uv[i], ut[i], uw[i]);
         end
         if (i < 4) tick();
      end
      s_en = 1'b0;
      #1;
      n_tests++;
      if (s_tc !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_en_off_tc: tc=%b want 0", s_tc);
      end
      tick();
      n_tests++;
      if (s_valor !== 4'd9 || s_wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_en_off: valor=%0d wrap=%b want 9/0", s_valor, s_wrap);
      end
      s_lv = 4'd1; s_load = 1'b1; tick(); s_load = 1'b0;
      s_en = 1'b1; s_up = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (s_valor !== dv[i] || s_wrap !== dw[i]) begin
            n_fail++;
            $display("FAIL sat_down%0d: valor=%0d wrap=%b want %0d/%b",
                     i, s_valor, s_wrap, dv[i], dw[i]);
         end
         tick();
      end
      s_en = 1'b0;
   endtask

   task automatic test_priority();
      a_lv = 4'd5; a_load = 1'b1; tick();
      a_clr = 1'b1; a_load = 1'b1; a_en = 1'b1; a_up = 1'b1; a_lv = 4'd3;
      #1;
      n_tests++;
      if (a_tc !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_tc: tc=%b want 0", a_tc);
      end
      tick();
      n_tests++;
      if (a_valor !== 4'd0 || a_wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_clr: valor=%0d wrap=%b want 0/0", a_valor, a_wrap);
      end
      a_clr = 1'b0; a_lv = 4'd13;
      tick();
      n_tests++;
      if (a_valor !== 4'd9) begin
         n_fail++;
         $display("FAIL load_clamp: valor=%0d want 9", a_valor);
      end
      a_load = 1'b0; a_en = 1'b0;
      #1;
      n_tests++;
      if (a_tc !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_tc: tc=%b want 0", a_tc);
      end
      tick();
      n_tests++;
      if (a_valor !== 4'd9 || a_wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL hold: valor=%0d wrap=%b want 9/0", a_valor, a_wrap);
      end
      a_lv = 4'd4; a_load = 1'b1; a_en = 1'b1;
      tick();
      n_tests++;
      if (a_valor !== 4'd4) begin
         n_fail++;
         $display("FAIL load_over_en: valor=%0d want 4", a_valor);
      end
      a_load = 1'b0; a_en = 1'b0;
   endtask

   task automatic test_direction_change();
      a_lv = 4'd5; a_load = 1'b1; tick(); a_load = 1'b0;
      a_en = 1'b1; a_up = 1'b1;
      tick();
      n_tests++;
      if (a_valor !== 4'd6) begin
         n_fail++;
         $display("FAIL dir_up: valor=%0d want 6", a_valor);
      end
      a_up = 1'b0;
      tick();
      n_tests++;
      if (a_valor !== 4'd5) begin
         n_fail++;
         $display("FAIL dir_down: valor=%0d want 5", a_valor);
      end
      a_en = 1'b0;
   endtask

   task automatic test_full_range();
      f_lv = 4'd15; f_load = 1'b1; tick(); f_load = 1'b0;
      f_en = 1'b1; f_up = 1'b1;
      #1;
      n_tests++;
      if (f_valor !== 4'd15 || f_tc !== 1'b1) begin
         n_fail++;
         $display("FAIL full_top: valor=%0d tc=%b want 15/1", f_valor, f_tc);
      end
      tick();
      n_tests++;
      if (f_valor !== 4'd0 || f_wrap !== 1'b1) begin
         n_fail++;
         $display("FAIL full_up_wrap: valor=%0d wrap=%b want 0/1", f_valor, f_wrap);
      end
      f_up = 1'b0;
      #1;
      n_tests++;
      if (f_tc !== 1'b1) begin
         n_fail++;
         $display("FAIL full_bot_tc: tc=%b want 1", f_tc);
      end
      tick();
      n_tests++;
      if (f_valor !== 4'd15 || f_wrap !== 1'b1) begin
         n_fail++;
         $display("FAIL full_down_wrap: valor=%0d wrap=%b want 15/1", f_valor, f_wrap);
      end
      tick();
      n_tests++;
      if (f_valor !== 4'd14 || f_wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL full_down_next: valor=%0d wrap=%b want 14/0", f_valor, f_wrap);
      end
      f_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_saturate();
      test_priority();
      test_direction_change();
      test_full_range();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
